// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_conditioner_pkg
// Shared definitions for the input conditioner:
//   req_e                    - 2-bit code held in the one-entry request slot
//   DEFAULT_DEBOUNCE_CYCLES  - stable cycles needed to accept a button level
//                              (20 ms at 50 MHz)
//   DEFAULT_SYNC_STAGES      - flip-flop depth of each raw-input synchronizer
// -----------------------------------------------------------------------------
package input_conditioner_pkg;

   typedef enum logic [1:0] {
      REQ_NONE     = 2'd0,
      REQ_RETURN   = 2'd1,
      REQ_ZOOM_IN  = 2'd2,
      REQ_ZOOM_OUT = 2'd3
   } req_e;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/input_conditioner_button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Synchronizes one raw active-low push-button, debounces it and flags presses.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   btn_n_i  in   raw asynchronous button, low = pressed
//   press_o  out  high for the one cycle whose closing edge moves the debounced
//                 level from 1 to 0; the consumer captures it on that edge, so
//                 the press is visible in its registers the cycle after
// -----------------------------------------------------------------------------
module button_debouncer
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n_i,
   output logic press_o
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '1;
         cnt_q   <= '0;
         level_q <= 1'b1;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   // The counter only advances while the synchronized level disagrees with the
   // accepted level; any agreement restarts it. The last mismatching cycle
   // (count DEBOUNCE_CYCLES-1 plus this one) commits the new level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (synced != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = synced;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign press_o = level_q & ~level_d;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Conditions three push-buttons and a 4-bit one-hot algorithm switch for a
// downstream controller. Button presses are debounced, arbitrated into a
// one-entry request slot and issued as single-cycle pulses when the
// controller is idle and the switch setting is valid.
// Ports:
//   clk                       in   system clock, rising edge
//   reset                     in   asynchronous active-low reset
//   btn_zoom_in_n             in   raw button, low = pressed
//   btn_zoom_out_n            in   raw button, low = pressed
//   btn_return_n              in   raw button, low = pressed
//   sw[3:0]                   in   raw algorithm switches, expected one-hot
//   busy                      in   downstream controller is processing
//   zoom_in                   out  request pulse
//   zoom_out                  out  request pulse
//   return_to_previous        out  request pulse
//   algorithm_select[1:0]     out  index of the single active switch (held)
//   multiple_switches_error   out  more than one switch set
//   no_switch_selected_error  out  no switch set
//   request_dropped           out  sticky: some press was discarded
// -----------------------------------------------------------------------------
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_zoom_in_n,
   input  logic       btn_zoom_out_n,
   input  logic       btn_return_n,
   input  logic [3:0] sw,
   input  logic       busy,
   output logic       zoom_in,
   output logic       zoom_out,
   output logic       return_to_previous,
   output logic [1:0] algorithm_select,
   output logic       multiple_switches_error,
   output logic       no_switch_selected_error,
   output logic       request_dropped
);

   logic press_ret, press_in, press_out;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
      u_db_return   (.clk(clk), .reset(reset), .btn_n_i(btn_return_n),   .press_o(press_ret));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
      u_db_zoom_in  (.clk(clk), .reset(reset), .btn_n_i(btn_zoom_in_n),  .press_o(press_in));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
      u_db_zoom_out (.clk(clk), .reset(reset), .btn_n_i(btn_zoom_out_n), .press_o(press_out));

   // ---------------- switch synchronizer and decode ----------------
   logic [SYNC_STAGES-1:0][3:0] sw_sync_q;
   logic [3:0]                  sw_s;
   logic [1:0]                  alg_q, alg_d;
   logic                        multi_q, multi_d;
   logic                        nosw_q, nosw_d;

   assign sw_s = sw_sync_q[SYNC_STAGES-1];

   always_comb begin
      alg_d   = alg_q;
      nosw_d  = (sw_s == 4'd0);
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi_d = ((sw_s & (sw_s - 4'd1)) != 4'd0);
      if (!nosw_d && !multi_d) begin
         case (sw_s)
            4'b0001: alg_d = 2'b00;
            4'b0010: alg_d = 2'b01;
            4'b0100: alg_d = 2'b10;
            4'b1000: alg_d = 2'b11;
            default: alg_d = alg_q;
         endcase
      end
   end

   // ---------------- request slot and issue ----------------
   req_e slot_q, slot_d;
   logic ret_q, ret_d, zin_q, zin_d, zout_q, zout_d, drop_q, drop_d;

   // A full slot leaves whenever busy is low (issued, or discarded on a switch
   // error), so a press landing on that same edge can take its place. Presses
   // are offered in priority order; each one that finds the slot taken is lost.
   always_comb begin
      slot_d = slot_q;
      drop_d = drop_q;
      ret_d  = 1'b0;
      zin_d  = 1'b0;
      zout_d = 1'b0;
      if (slot_q != REQ_NONE && !busy) begin
         if (multi_q || nosw_q) begin
            drop_d = 1'b1;
         end else begin
            case (slot_q)
               REQ_RETURN:   ret_d  = 1'b1;
               REQ_ZOOM_IN:  zin_d  = 1'b1;
               REQ_ZOOM_OUT: zout_d = 1'b1;
               default:      ;
            endcase
         end
         slot_d = REQ_NONE;
      end
      if (press_ret) begin
         if (slot_d == REQ_NONE) slot_d = REQ_RETURN;
         else                    drop_d = 1'b1;
      end
      if (press_in) begin
         if (slot_d == REQ_NONE) slot_d = REQ_ZOOM_IN;
         else                    drop_d = 1'b1;
      end
      if (press_out) begin
         if (slot_d == REQ_NONE) slot_d = REQ_ZOOM_OUT;
         else                    drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_sync_q <= '0;
         alg_q     <= 2'b00;
         multi_q   <= 1'b0;
         nosw_q    <= 1'b1;
         slot_q    <= REQ_NONE;
         ret_q     <= 1'b0;
         zin_q     <= 1'b0;
         zout_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], sw};
         alg_q     <= alg_d;
         multi_q   <= multi_d;
         nosw_q    <= nosw_d;
         slot_q    <= slot_d;
         ret_q     <= ret_d;
         zin_q     <= zin_d;
         zout_q    <= zout_d;
         drop_q    <= drop_d;
      end
   end

   assign zoom_in                  = zin_q;
   assign zoom_out                 = zout_q;
   assign return_to_previous       = ret_q;
   assign algorithm_select         = alg_q;
   assign multiple_switches_error  = multi_q;
   assign no_switch_selected_error = nosw_q;
   assign request_dropped          = drop_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

   localparam int DC = 4;
   localparam int SS = 2;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] btn_raw;   // [0]=return, [1]=zoom_in, [2]=zoom_out (priority order)
   logic [3:0] sw;
   logic       busy;
   logic       zoom_in, zoom_out, return_to_previous;
   logic [1:0] algorithm_select;
   logic       multiple_switches_error, no_switch_selected_error, request_dropped;

   always #5 clk = ~clk;

   input_conditioner #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .btn_zoom_in_n            (btn_raw[1]),
      .btn_zoom_out_n           (btn_raw[2]),
      .btn_return_n             (btn_raw[0]),
      .sw                       (sw),
      .busy                     (busy),
      .zoom_in                  (zoom_in),
      .zoom_out                 (zoom_out),
      .return_to_previous       (return_to_previous),
      .algorithm_select         (algorithm_select),
      .multiple_switches_error  (multiple_switches_error),
      .no_switch_selected_error (no_switch_selected_error),
      .request_dropped          (request_dropped)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int pulse_cnt[3];
   int pulse_at[3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Buttons: the synchronized value seen at an edge is the raw value sampled
   // SS edges earlier; the accepted level flips once the last DC seen values
   // all disagree with it.
   logic       raw_h[3][$];
   logic       seen_h[3][$];
   logic       m_deb[3];
   logic [3:0] sw_h[$];
   int         m_slot;      // 0 empty, else 1 + button index
   logic       m_multi, m_nosw, m_drop;
   logic [1:0] m_alg;
   logic [2:0] e_pulse;

   task automatic model_reset();
      for (int b = 0; b < 3; b++) begin
         raw_h[b].delete();
         seen_h[b].delete();
         m_deb[b] = 1'b1;
      end
      sw_h.delete();
      m_slot  = 0;
      m_multi = 1'b0;
      m_nosw  = 1'b1;
      m_drop  = 1'b0;
      m_alg   = 2'b00;
      e_pulse = 3'b000;
   endtask

   task automatic model_edge();
      logic [2:0] press;
      logic       s, all_diff;
      logic [3:0] sws;
      int         ones;
      press = 3'b000;
      for (int b = 0; b < 3; b++) begin
         raw_h[b].push_back(btn_raw[b]);
         if (raw_h[b].size() > SS + 1) void'(raw_h[b].pop_front());
         s = (raw_h[b].size() == SS + 1) ? raw_h[b][0] : 1'b1;
         seen_h[b].push_back(s);
         if (seen_h[b].size() > DC) void'(seen_h[b].pop_front());
         if (seen_h[b].size() == DC) begin
            all_diff = 1'b1;
            for (int k = 0; k < DC; k++) if (seen_h[b][k] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) begin
               press[b] = m_deb[b];
               m_deb[b] = ~m_deb[b];
            end
         end
      end
      sw_h.push_back(sw);
      if (sw_h.size() > SS + 1) void'(sw_h.pop_front());
      sws = (sw_h.size() == SS + 1) ? sw_h[0] : 4'b0000;

      e_pulse = 3'b000;
      if (m_slot != 0 && !busy) begin
         if (m_multi || m_nosw) m_drop = 1'b1;
         else                   e_pulse[m_slot-1] = 1'b1;
         m_slot = 0;
      end
      for (int b = 0; b < 3; b++) begin
         if (press[b]) begin
            if (m_slot == 0) m_slot = b + 1;
            else             m_drop = 1'b1;
         end
      end

      ones    = $countones(sws);
      m_nosw  = (ones == 0);
      m_multi = (ones > 1);
      if (ones == 1) for (int k = 0; k < 4; k++) if (sws[k]) m_alg = k[1:0];
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_track();
      cyc = 0;
      for (int b = 0; b < 3; b++) begin
         pulse_cnt[b] = 0;
         pulse_at[b]  = 0;
      end
   endtask

   task automatic step();
      logic [2:0] outs;
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check("m_return", return_to_previous, e_pulse[0]);
      check("m_zoom_in", zoom_in, e_pulse[1]);
      check("m_zoom_out", zoom_out, e_pulse[2]);
      check("m_alg", algorithm_select, m_alg);
      check("m_multi", multiple_switches_error, m_multi);
      check("m_nosw", no_switch_selected_error, m_nosw);
      check("m_dropped", request_dropped, m_drop);
      outs = {zoom_out, zoom_in, return_to_previous};
      for (int b = 0; b < 3; b++) begin
         if (outs[b]) begin
            pulse_cnt[b]++;
            pulse_at[b] = cyc;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_return"},  return_to_previous, 0);
      check({tag, "_zoom_in"}, zoom_in, 0);
      check({tag, "_zoom_out"}, zoom_out, 0);
      check({tag, "_alg"},     algorithm_select, 0);
      check({tag, "_multi"},   multiple_switches_error, 0);
      check({tag, "_nosw"},    no_switch_selected_error, 1);
      check({tag, "_dropped"}, request_dropped, 0);
   endtask

   // Asserts reset wherever the bench currently is, checks the asynchronous
   // clear, then releases it on a falling edge.
   task automatic assert_reset_now(input string tag);
      reset   = 1'b0;
      btn_raw = 3'b111;
      busy    = 1'b0;
      #1;
      check_reset_outputs(tag);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      assert_reset_now(tag);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [2:0] press;     // buttons held low from cycle 0
      logic [3:0] sw;
      int         busy_cyc;  // busy high for cycles [0, busy_cyc)
      int         run_len;
      logic [2:0] exp_pulse; // which output pulses once
      int         exp_at;
      logic       exp_drop;
      logic       exp_multi;
      logic       exp_nosw;
      logic [1:0] exp_alg;
   } vec_t;

   vec_t vecs[9];

   int hold[3];

   initial begin
      reset   = 1'b0;
      btn_raw = 3'b111;
      sw      = 4'b0000;
      busy    = 1'b0;
      model_reset();

      vecs[0] = '{3'b010, 4'b0001, 0,  16, 3'b010, 7,  1'b0, 1'b0, 1'b0, 2'b00};
      vecs[1] = '{3'b100, 4'b0100, 0,  16, 3'b100, 7,  1'b0, 1'b0, 1'b0, 2'b10};
      vecs[2] = '{3'b001, 4'b1000, 0,  16, 3'b001, 7,  1'b0, 1'b0, 1'b0, 2'b11};
      vecs[3] = '{3'b011, 4'b0010, 0,  16, 3'b001, 7,  1'b1, 1'b0, 1'b0, 2'b01};
      vecs[4] = '{3'b110, 4'b0001, 0,  16, 3'b010, 7,  1'b1, 1'b0, 1'b0, 2'b00};
      vecs[5] = '{3'b111, 4'b0100, 0,  16, 3'b001, 7,  1'b1, 1'b0, 1'b0, 2'b10};
      vecs[6] = '{3'b100, 4'b0110, 0,  16, 3'b000, 0,  1'b1, 1'b1, 1'b0, 2'b00};
      vecs[7] = '{3'b010, 4'b0000, 0,  16, 3'b000, 0,  1'b1, 1'b0, 1'b1, 2'b00};
      vecs[8] = '{3'b001, 4'b0001, 30, 40, 3'b001, 31, 1'b0, 1'b0, 1'b0, 2'b00};

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 9; i++) begin
         do_reset($sformatf("v%0d_rst", i));
         sw      = vecs[i].sw;
         btn_raw = ~vecs[i].press;
         clear_track();
         for (int c = 0; c < vecs[i].run_len; c++) begin
            busy = (c < vecs[i].busy_cyc);
            step();
         end
         for (int b = 0; b < 3; b++) begin
            check($sformatf("v%0d_cnt%0d", i, b), pulse_cnt[b], vecs[i].exp_pulse[b] ? 1 : 0);
            if (vecs[i].exp_pulse[b])
               check($sformatf("v%0d_at%0d", i, b), pulse_at[b], vecs[i].exp_at);
         end
         check($sformatf("v%0d_dropped", i), request_dropped, vecs[i].exp_drop);
         check($sformatf("v%0d_multi", i), multiple_switches_error, vecs[i].exp_multi);
         check($sformatf("v%0d_nosw", i), no_switch_selected_error, vecs[i].exp_nosw);
         check($sformatf("v%0d_alg", i), algorithm_select, vecs[i].exp_alg);
      end

      // Bouncing zoom_out: never stable long enough, so nothing is issued.
      do_reset("bounce_rst");
      sw = 4'b0001;
      clear_track();
      for (int c = 0; c < 20; c++) begin
         btn_raw[2] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
         step();
      end
      btn_raw[2] = 1'b1;
      run(20);
      check("bounce_cnt", pulse_cnt[2], 0);
      check("bounce_dropped", request_dropped, 0);

      // A press completing on the issuing edge loads and issues one cycle later.
      do_reset("issue_rst");
      sw = 4'b0001;
      clear_track();
      btn_raw[1] = 1'b0;
      busy = 1'b1;
      step();
      btn_raw[2] = 1'b0;
      for (int c = 1; c < 20; c++) begin
         busy = (c < 6);
         step();
      end
      check("issue_in_cnt", pulse_cnt[1], 1);
      check("issue_in_at", pulse_at[1], 7);
      check("issue_out_cnt", pulse_cnt[2], 1);
      check("issue_out_at", pulse_at[2], 8);
      check("issue_dropped", request_dropped, 0);

      // Reset in the middle of a debounce discards the pending press.
      do_reset("mid_rst0");
      sw = 4'b0001;
      clear_track();
      btn_raw[1] = 1'b0;
      run(5);
      assert_reset_now("mid_rst");
      sw = 4'b0001;
      clear_track();
      run(12);
      check("mid_quiet_cnt", pulse_cnt[1], 0);
      clear_track();
      btn_raw[1] = 1'b0;
      run(12);
      check("mid_new_cnt", pulse_cnt[1], 1);
      check("mid_new_at", pulse_at[1], 7);

      // Reset while the slot holds a request: nothing appears afterwards.
      do_reset("full_rst0");
      sw = 4'b0001;
      clear_track();
      btn_raw[0] = 1'b0;
      busy = 1'b1;
      run(10);
      assert_reset_now("full_rst");
      sw = 4'b0001;
      clear_track();
      run(15);
      check("full_quiet_cnt", pulse_cnt[0], 0);

      // Randomized traffic against the model.
      do_reset("rand_rst");
      sw = 4'b0001;
      for (int b = 0; b < 3; b++) hold[b] = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (hold[b] == 0) begin
               btn_raw[b] = 1'($urandom_range(0, 1));
               hold[b]    = $urandom_range(1, 12);
            end else begin
               hold[b]--;
            end
         end
         if ($urandom_range(0, 7) == 0) busy = ~busy;
         if ($urandom_range(0, 39) == 0) begin
            if ($urandom_range(0, 9) < 7) sw = 4'b0001 << $urandom_range(0, 3);
            else                          sw = 4'($urandom_range(0, 15));
         end
         if (c == 750) begin
            @(negedge clk);
            assert_reset_now("rand_mid_rst");
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
